// File: rtl/clk_en_monitor_pkg.sv
// Shared types for the sample-rate strobe monitor: FSM states and interval classes.
package clk_en_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } mon_state_t;

    typedef enum logic [1:0] {
        GOOD,
        EARLY,
        LATE
    } interval_class_t;

    // lo/hi are the inclusive bounds of an acceptable interval
    function automatic interval_class_t classify(input int unsigned k,
                                                 input int unsigned lo,
                                                 input int unsigned hi);
        if (k < lo)
            return EARLY;
        else if (k > hi)
            return LATE;
        else
            return GOOD;
    endfunction

endpackage

// File: rtl/clk_en_monitor_if.sv
// Strobe input and status outputs of the strobe monitor, grouped for port reuse.
interface clk_en_monitor_if #(
    parameter int PERIOD_W = 10,
    parameter int GOOD_W   = 3
);
    logic                clk_en_in;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                locked;
    logic                err_early;
    logic                err_late;
    logic [GOOD_W-1:0]   good_count;

    modport master (
        output clk_en_in,
        input  period, period_valid, locked, err_early, err_late, good_count
    );

    modport slave (
        input  clk_en_in,
        output period, period_valid, locked, err_early, err_late, good_count
    );
endinterface

// File: rtl/clk_en_monitor_interval_counter.sv
// Cycles-since-last-strobe counter: loads 1 on a strobe, otherwise counts up and saturates.
module interval_counter #(
    parameter int WIDTH     = 10,
    parameter int THRESHOLD = 289
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    output logic [WIDTH-1:0] count,
    output logic             at_threshold
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= WIDTH'(1);
        else if (count != '1)
            count <= count + 1'b1;
    end

    assign at_threshold = (count == WIDTH'(THRESHOLD));

endmodule

// File: rtl/clk_en_monitor.sv
// Periodic single-cycle strobe checker: measures strobe intervals, tracks lock,
// and flags early, late or missing strobes. All status outputs are registered.
module clk_en_monitor
    import clk_en_mon_pkg::*;
#(
    parameter int EXPECTED_PERIOD = 288,
    parameter int TOLERANCE       = 0,
    parameter int LOCK_COUNT      = 4,
    parameter int PERIOD_W        = $clog2(2*EXPECTED_PERIOD+1)
) (
    input  logic             clk,
    input  logic             reset_n,
    clk_en_monitor_if.slave  mon
);

    localparam int unsigned LO_LIMIT = EXPECTED_PERIOD - TOLERANCE;
    localparam int unsigned HI_LIMIT = EXPECTED_PERIOD + TOLERANCE;
    localparam int          GOOD_W   = $clog2(LOCK_COUNT+1);

    mon_state_t          state;
    interval_class_t     iclass;
    logic [PERIOD_W-1:0] count;
    logic                at_threshold;
    logic                strobe;

    logic [PERIOD_W-1:0] period_q;
    logic                period_valid_q;
    logic                locked_q;
    logic                err_early_q;
    logic                err_late_q;
    logic [GOOD_W-1:0]   good_count_q;
    logic [GOOD_W-1:0]   good_inc;

    assign strobe   = mon.clk_en_in;
    assign good_inc = good_count_q + 1'b1;

    interval_counter #(
        .WIDTH     (PERIOD_W),
        .THRESHOLD (HI_LIMIT + 1)
    ) u_counter (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (strobe),
        .count        (count),
        .at_threshold (at_threshold)
    );

    assign iclass = classify(32'(count), LO_LIMIT, HI_LIMIT);

    // A strobe coinciding with the threshold is a late interval, so strobe wins over timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_early_q    <= 1'b0;
            err_late_q     <= 1'b0;
            good_count_q   <= '0;
        end else begin
            period_valid_q <= 1'b0;
            err_early_q    <= 1'b0;
            err_late_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe)
                        state <= ACQUIRE;
                end
                ACQUIRE, LOCKED: begin
                    if (strobe) begin
                        period_q       <= count;
                        period_valid_q <= 1'b1;
                        case (iclass)
                            GOOD: begin
                                if (good_count_q != GOOD_W'(LOCK_COUNT)) begin
                                    good_count_q <= good_inc;
                                    if (good_inc == GOOD_W'(LOCK_COUNT)) begin
                                        state    <= LOCKED;
                                        locked_q <= 1'b1;
                                    end
                                end
                            end
                            EARLY: begin
                                err_early_q  <= 1'b1;
                                good_count_q <= '0;
                                locked_q     <= 1'b0;
                                state        <= ACQUIRE;
                            end
                            default: begin
                                err_late_q   <= 1'b1;
                                good_count_q <= '0;
                                locked_q     <= 1'b0;
                                state        <= ACQUIRE;
                            end
                        endcase
                    end else if (at_threshold) begin
                        err_late_q   <= 1'b1;
                        good_count_q <= '0;
                        locked_q     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mon.period       = period_q;
    assign mon.period_valid = period_valid_q;
    assign mon.locked       = locked_q;
    assign mon.err_early    = err_early_q;
    assign mon.err_late     = err_late_q;
    assign mon.good_count   = good_count_q;

endmodule
